// File: rtl/serial_parity_checker_if.sv
// -----------------------------------------------------------------------------
// serial_parity_checker_if
//   Handshake bundle for serial_parity_checker.
//   Input stream : in_bit / in_valid (producer -> checker), in_ready (checker -> producer)
//   Result stream: out_data / out_err / out_valid (checker -> consumer),
//                  out_ready (consumer -> checker)
//   Modports:
//     master : the environment side (drives serial bits, consumes results)
//     slave  : the checker side
// -----------------------------------------------------------------------------
interface serial_parity_checker_if #(
  parameter int unsigned FRAME_LEN = 8
) ();
  logic                 in_bit;
  logic                 in_valid;
  logic                 in_ready;
  logic [FRAME_LEN-1:0] out_data;
  logic                 out_err;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_bit, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  in_bit, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/serial_parity_checker.sv
// -----------------------------------------------------------------------------
// serial_parity_checker
//   Collects FRAME_LEN data bits (MSB first) followed by one parity bit from a
//   valid/ready serial stream, then presents the frame and a parity-error flag
//   on a valid/ready result port. One frame is held at a time; the input is
//   stalled (in_ready=0) while a result waits for the consumer.
//
//   Parameters:
//     FRAME_LEN  : data bits per frame (2..32)
//     ODD_PARITY : 0 = XOR(data, parity) must be 0; 1 = it must be 1
//
//   Ports:
//     clk        : clock, rising edge
//     rst        : asynchronous, active-high reset
//     bus        : serial_parity_checker_if.slave (in_bit/in_valid/in_ready,
//                  out_data/out_err/out_valid/out_ready)
//     err_count  : [7:0] saturating count of frames reported with out_err=1
//                  (present only when PARITY_ERR_CNT_EN is defined)
//
//   Build option: `define PARITY_ERR_CNT_EN to add the err_count output.
// -----------------------------------------------------------------------------
module serial_parity_checker #(
  parameter int unsigned FRAME_LEN  = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_parity_checker_if.slave        bus
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]                    err_count
`endif
);

  // Counter only needs to reach FRAME_LEN-1, so a power-of-two FRAME_LEN fits
  // exactly in $clog2(FRAME_LEN) bits without overflowing before the compare.
  localparam int unsigned     CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_DATA   = 2'd0,
    ST_PARITY = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 acc_q,   acc_d;
  logic [FRAME_LEN-1:0] sr_q,    sr_d;
  logic [FRAME_LEN-1:0] data_q,  data_d;
  logic                 err_q,   err_d;
  logic                 valid_q, valid_d;
  logic                 result_load;

  // Ready depends on registered state only: no in_valid -> in_ready path.
  assign bus.in_ready  = (state_q != ST_REPORT);
  assign bus.out_data  = data_q;
  assign bus.out_err   = err_q;
  assign bus.out_valid = valid_q;

  // NOTE: every signal assigned in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sr_d        = sr_q;
    data_d      = data_q;
    err_d       = err_q;
    valid_d     = valid_q;
    result_load = 1'b0;

    unique case (state_q)
      // in_ready is 1 in DATA and PARITY, so in_valid alone means a transfer.
      ST_DATA: begin
        if (bus.in_valid) begin
          sr_d  = {sr_q[FRAME_LEN-2:0], bus.in_bit};
          acc_d = acc_q ^ bus.in_bit;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = ST_PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (bus.in_valid) begin
          data_d      = sr_q;
          err_d       = ((acc_q ^ bus.in_bit) != ODD_PARITY);
          valid_d     = 1'b1;
          acc_d       = 1'b0;
          result_load = 1'b1;
          state_d     = ST_REPORT;
        end
      end

      ST_REPORT: begin
        // data/err deliberately keep their values after the handshake.
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          state_d = ST_DATA;
        end
      end

      default: state_d = ST_DATA;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DATA;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      sr_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts in the same cycle out_valid rises with an error; sticks at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (result_load && err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  // result_load only feeds the optional error counter.
  logic unused_result_load;
  assign unused_result_load = result_load;
`endif

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Serial-in parity checker for the gates library: a running XOR accumulator over a bit stream, collecting one frame at a time.
- Frame format: FRAME_LEN data bits, MSB first, followed by one parity bit.
- Shifts data into a register and compares the accumulated XOR against the received parity bit.
- Presents the frame plus an error flag to a downstream consumer over a valid/ready handshake.

Parameters:
FRAME_LEN, 8, number of data bits per frame (2..32)
ODD_PARITY, 0, 0 = even parity expected (XOR of data^parity == 0); 1 = odd parity expected (== 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_bit  input  1  serial data/parity bit
in_valid  input  1  in_bit is valid this cycle
in_ready  output  1  block accepts in_bit this cycle
out_data  output  FRAME_LEN  received data bits, first bit received in the MSB
out_err  output  1  1 = parity mismatch for out_data
out_valid  output  1  result available
out_ready  input  1  consumer takes the result this cycle

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=DATA, bit counter=0, accumulator=0, shift register=0, out_data=0, out_err=0, out_valid=0, in_ready=1.
- Input transfer occurs on a rising edge with in_valid & in_ready. in_ready = (state != REPORT). No combinational path from in_valid to in_ready.
- State DATA:
  - Each accepted bit: shift register <= {sr[FRAME_LEN-2:0], in_bit}; acc <= acc ^ in_bit; count++.
  - On the accepted bit where count == FRAME_LEN-1, go to PARITY and clear count.
- State PARITY:
  - Accepted bit p: out_data <= shift register.
  - out_err <= (acc ^ p) != ODD_PARITY.
  - out_valid <= 1; go to REPORT; clear acc.
- State REPORT:
  - in_ready=0; outputs stable while out_valid & !out_ready.
  - On out_valid & out_ready: out_valid <= 0, go to DATA.
  - out_data/out_err keep their last values after the handshake.
- Latency: out_valid rises in the cycle after the parity bit is accepted. Back-to-back throughput is FRAME_LEN+2 cycles per frame with out_ready held high; one bubble for REPORT.
- in_valid low: state, count and acc hold, so gaps anywhere inside a frame are legal.
- in_valid high in REPORT: ignored, not accepted; the sender must hold the bit.
- Reset mid-frame or mid-REPORT: the partial frame is discarded and the pending result is lost; all values return to reset values immediately (asynchronous).
- Count width is $clog2(FRAME_LEN); FRAME_LEN=2^k must not overflow before the compare.
- Illegal/unused state encodings go to DATA.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined:
  - Adds output err_count [7:0], reset 0.
  - Increments by 1 in the same cycle out_valid rises with out_err=1.
  - Saturates at 255 (no wrap).
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, FRAME_LEN=8, even parity: stream 1010_0110 then parity 0 with out_ready=1 -> out_valid=1 one cycle after the parity bit, out_data=8'hA6, out_err=0.
- Same data with parity 1 -> out_data=8'hA6, out_err=1; ODD_PARITY=1 build, same data, parity 1 -> out_err=0.
- Backpressure: out_ready=0 for 5 cycles after a result while in_valid=1 -> in_ready=0, out_data/out_err stable, no bits consumed. Raise out_ready -> next frame 8'hFF, parity 0 received correctly, out_err=0.
- Gaps: frame 8'h3C with in_valid low for 3 cycles after bits 2 and 7, parity 0 -> out_data=8'h3C, out_err=0, timing shifted by exactly 6 cycles.
- Async reset asserted between clock edges after 5 data bits -> all outputs at reset values before the next edge. Next full frame 8'h01, parity 1 -> out_data=8'h01, out_err=0, with no residue from the partial frame.
- PARITY_ERR_CNT_EN defined: 3 bad frames then 1 good -> err_count=3. Force 300 bad frames -> err_count=255.
